// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential
// shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_adder.sv
// Ripple adder with carry-out and signed
// condition codes.
module adderWithConditionCodes #(
  parameter int width = 8
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cIn,
  output logic [width-1:0] sum,
  output logic             cOut,
  output logic             neg,
  output logic             overFlow
);

  logic [width:0] full;

  // Sum and carry from a single wide add.
  always_comb begin
    full = {1'b0, a} + {1'b0, b}
         + {{width{1'b0}}, cIn};
  end

  assign sum      = full[width-1:0];
  assign cOut     = full[width];
  assign neg      = full[width-1];
  assign overFlow = (a[width-1] == b[width-1])
                 && (full[width-1] != a[width-1]);

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned shift-and-add multiplier, one
// partial product per clock, valid/ready in/out.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               zero
);

  localparam int CW = clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             unused_neg;
  logic             unused_ovf;
  logic [PW-1:0]    shifted;

  assign add_b = acc_lo_q[0] ? mcand_q : '0;

  adderWithConditionCodes #(
    .width(WIDTH)
  ) u_add (
    .a       (acc_hi_q),
    .b       (add_b),
    .cIn     (1'b0),
    .sum     (add_sum),
    .cOut    (add_cout),
    .neg     (unused_neg),
    .overFlow(unused_ovf)
  );

  assign shifted = {add_cout, add_sum,
                    acc_lo_q[WIDTH-1:1]};

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          acc_hi_d = '0;
          acc_lo_d = b;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_hi_d = shifted[PW-1:WIDTH];
        acc_lo_d = shifted[WIDTH-1:0];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          product_d   = shifted;
          zero_d      = (shifted == '0);
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier
// at WIDTH=8.
module tb_seq_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        zero;

  int n_tests;
  int n_fail;
  int lat;

  seq_shift_add_multiplier #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // Present operands, wait for the result;
  // returns edges from accept to out_valid.
  task automatic do_op(input logic [7:0] x,
                       input logic [7:0] y,
                       input logic scramble,
                       output int l);
    check("pre_in_ready", 32'(in_ready), 1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("acc_in_ready", 32'(in_ready), 0);
    if (!scramble) in_valid = 1'b0;
    l = 0;
    while (!out_valid && l < 20) begin
      if (scramble) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
      @(posedge clk); #1;
      l = l + 1;
    end
    in_valid = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 0);
    check("post_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_product", 32'(product), 0);
    check("rst_zero", 32'(zero), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 13 * 11, then backpressure in DONE
    do_op(8'd13, 8'd11, 1'b0, lat);
    check("basic_lat", 32'(lat), 8);
    check("basic_prod", 32'(product), 32'h008F);
    check("basic_zero", 32'(zero), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_prod", 32'(product), 32'h008F);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    take_result();
    do_op(8'd3, 8'd5, 1'b0, lat);
    check("after_bp_lat", 32'(lat), 8);
    check("after_bp_prod", 32'(product), 15);
    take_result();

    // 255 * 255, out_ready held high all along
    out_ready = 1'b1;
    do_op(8'd255, 8'd255, 1'b0, lat);
    check("max_lat", 32'(lat), 8);
    check("max_prod", 32'(product), 32'hFE01);
    check("max_zero", 32'(zero), 0);
    take_result();

    // 0 * 200
    do_op(8'd0, 8'd200, 1'b0, lat);
    check("zero_lat", 32'(lat), 8);
    check("zero_prod", 32'(product), 0);
    check("zero_flag", 32'(zero), 1);
    take_result();

    // reset in the third RUN cycle
    a = 8'd7;
    b = 8'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(out_valid), 0);
    check("mrst_product", 32'(product), 0);
    check("mrst_zero", 32'(zero), 0);
    check("mrst_in_ready", 32'(in_ready), 1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_no_result", 32'(out_valid), 0);
    do_op(8'd3, 8'd5, 1'b0, lat);
    check("mrst_lat", 32'(lat), 8);
    check("mrst_prod", 32'(product), 15);
    take_result();

    // operand churn during RUN
    do_op(8'd200, 8'd100, 1'b1, lat);
    check("churn_lat", 32'(lat), 8);
    check("churn_prod", 32'(product), 32'h4E20);
    check("churn_zero", 32'(zero), 0);
    take_result();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
